// File: rtl/alu_issue_sequencer.sv
// Operand-issue stage in front of the 32-bit ALU.
// Holds a 4 x 32-bit operand bank, accepts one command at a time, and drives
// A/B/FunSel/WF for CmdRep+1 iterations. On each repeat the ALU result is fed
// back as A, so single-bit shift ops become multi-bit shifts. The final ALU
// result is optionally written back to the bank and offered on Result.
//
// Handshakes: a transfer happens on a rising Clock edge where both valid and
// ready are high. CmdReady is high only in IDLE and does not depend on
// CmdValid. ResultValid is high only in DONE, and Result stays stable until
// the edge where ResultReady is seen high. No command is taken on that edge.
module alu_issue_sequencer #(
  parameter int REP_W = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             CmdValid,
  output logic             CmdReady,
  input  logic [4:0]       CmdFunSel,
  input  logic [1:0]       CmdSrcA,
  input  logic [1:0]       CmdSrcB,
  input  logic [1:0]       CmdDst,
  input  logic             CmdWrite,
  input  logic             CmdSetFlags,
  input  logic [REP_W-1:0] CmdRep,
  input  logic             LoadEn,
  input  logic [1:0]       LoadAddr,
  input  logic [31:0]      LoadData,
  output logic [31:0]      A,
  output logic [31:0]      B,
  output logic [4:0]       FunSel,
  output logic             WF,
  input  logic [31:0]      ALUOut,
  output logic [31:0]      Result,
  output logic             ResultValid,
  input  logic             ResultReady,
  output logic             Busy,
  output logic [1:0]       DebugState
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [31:0]      bank [4];
  logic [REP_W-1:0] count;
  logic [1:0]       dst;
  logic             write_en;
  logic [31:0]      src_a;
  logic [31:0]      src_b;
  logic             last_issue;
  logic             final_wb;

  // A direct load landing on a source index in the acceptance cycle is seen
  // by the operand, so the command never reads a stale register.
  assign src_a = (LoadEn && (LoadAddr == CmdSrcA)) ? LoadData : bank[CmdSrcA];
  assign src_b = (LoadEn && (LoadAddr == CmdSrcB)) ? LoadData : bank[CmdSrcB];

  assign last_issue = (state == ISSUE) && (count == '0);
  assign final_wb   = last_issue && write_en;

  assign CmdReady   = (state == IDLE);
  assign Busy       = ~CmdReady;
  assign DebugState = state;

  // Operand bank: direct loads in any state; the final writeback is ordered
  // after the load so it wins when both target the same index.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      bank[0] <= '0;
      bank[1] <= '0;
      bank[2] <= '0;
      bank[3] <= '0;
    end else begin
      if (LoadEn) begin
        bank[LoadAddr] <= LoadData;
      end
      if (final_wb) begin
        bank[dst] <= ALUOut;
      end
    end
  end

  // Command FSM with registered ALU-side outputs; A/B/FunSel/WF are zero
  // everywhere except ISSUE so the ALU never sees a spurious flag write.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      A           <= '0;
      B           <= '0;
      FunSel      <= '0;
      WF          <= 1'b0;
      count       <= '0;
      dst         <= '0;
      write_en    <= 1'b0;
      Result      <= '0;
      ResultValid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (CmdValid) begin
            state    <= ISSUE;
            A        <= src_a;
            B        <= src_b;
            FunSel   <= CmdFunSel;
            WF       <= CmdSetFlags;
            count    <= CmdRep;
            dst      <= CmdDst;
            write_en <= CmdWrite;
          end
        end
        ISSUE: begin
          if (last_issue) begin
            state       <= DONE;
            Result      <= ALUOut;
            ResultValid <= 1'b1;
            A           <= '0;
            B           <= '0;
            FunSel      <= '0;
            WF          <= 1'b0;
          end else begin
            A     <= ALUOut;
            count <= count - REP_W'(1);
          end
        end
        DONE: begin
          if (ResultReady) begin
            state       <= IDLE;
            ResultValid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Bench for alu_issue_sequencer: a small behavioural ALU closes the loop on
// ALUOut, a reference model of the bank and command sequencing produces a
// per-cycle expectation queue, and one negedge process checks the DUT
// against it. Directed cases pin known literal values.
module tb_alu_issue_sequencer;

  localparam int REP_W = 4;

  // ---------------- clock / reset ----------------
  logic             Clock;
  logic             Reset;
  logic             CmdValid;
  logic             CmdReady;
  logic [4:0]       CmdFunSel;
  logic [1:0]       CmdSrcA;
  logic [1:0]       CmdSrcB;
  logic [1:0]       CmdDst;
  logic             CmdWrite;
  logic             CmdSetFlags;
  logic [REP_W-1:0] CmdRep;
  logic             LoadEn;
  logic [1:0]       LoadAddr;
  logic [31:0]      LoadData;
  logic [31:0]      A;
  logic [31:0]      B;
  logic [4:0]       FunSel;
  logic             WF;
  logic [31:0]      ALUOut;
  logic [31:0]      Result;
  logic             ResultValid;
  logic             ResultReady;
  logic             Busy;
  logic [1:0]       DebugState;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  alu_issue_sequencer #(.REP_W(REP_W)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .CmdValid    (CmdValid),
    .CmdReady    (CmdReady),
    .CmdFunSel   (CmdFunSel),
    .CmdSrcA     (CmdSrcA),
    .CmdSrcB     (CmdSrcB),
    .CmdDst      (CmdDst),
    .CmdWrite    (CmdWrite),
    .CmdSetFlags (CmdSetFlags),
    .CmdRep      (CmdRep),
    .LoadEn      (LoadEn),
    .LoadAddr    (LoadAddr),
    .LoadData    (LoadData),
    .A           (A),
    .B           (B),
    .FunSel      (FunSel),
    .WF          (WF),
    .ALUOut      (ALUOut),
    .Result      (Result),
    .ResultValid (ResultValid),
    .ResultReady (ResultReady),
    .Busy        (Busy),
    .DebugState  (DebugState)
  );

  // ---------------- behavioural ALU (environment) ----------------
  localparam logic [4:0] OP_PASS = 5'b10000;
  localparam logic [4:0] OP_ADD  = 5'b10100;
  localparam logic [4:0] OP_SUB  = 5'b10101;
  localparam logic [4:0] OP_XOR  = 5'b10111;
  localparam logic [4:0] OP_LSL  = 5'b11011;
  localparam logic [4:0] OP_LSR  = 5'b11100;
  localparam logic [4:0] OP_ROL  = 5'b11110;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] f);
    case (f)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_XOR:  return a ^ b;
      OP_LSL:  return a << 1;
      OP_LSR:  return a >> 1;
      OP_ROL:  return {a[30:0], a[31]};
      default: return a;
    endcase
  endfunction

  assign ALUOut = alu_f(A, B, FunSel);

  // ---------------- reference model state ----------------
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic [4:0]  f;
    logic        wf;
    logic        rv;
    logic        ready;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_bank [4];
  logic [31:0] last_result;
  int          n_checks;
  int          n_pass;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard compare (one per cycle) ----------------
  exp_t cur;
  always @(negedge Clock) begin
    if (Reset && (exp_q.size() > 0)) begin
      cur = exp_q.pop_front();
      check("cyc_A",           A,                   cur.a);
      check("cyc_B",           B,                   cur.b);
      check("cyc_FunSel",      32'(FunSel),         32'(cur.f));
      check("cyc_WF",          32'(WF),             32'(cur.wf));
      check("cyc_ResultValid", 32'(ResultValid),    32'(cur.rv));
      check("cyc_Result",      Result,              cur.result);
      check("cyc_CmdReady",    32'(CmdReady),       32'(cur.ready));
      check("cyc_Busy",        32'(Busy),           32'(!cur.ready));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic push_idle();
    exp_t e;
    e = '{a: 32'd0, b: 32'd0, result: last_result, f: 5'd0, wf: 1'b0, rv: 1'b0, ready: 1'b1};
    exp_q.push_back(e);
  endtask

  // Model of the bank update caused by this cycle's LoadEn at the coming edge.
  task automatic apply_load();
    if (LoadEn) m_bank[LoadAddr] = LoadData;
  endtask

  task automatic drive_load(input int cyc, input int ld_cycle, input logic rnd,
                            input logic [1:0] la, input logic [31:0] ld);
    if (cyc == ld_cycle) begin
      LoadEn = 1'b1; LoadAddr = la; LoadData = ld;
    end else if (rnd && ($urandom_range(0, 3) == 0)) begin
      LoadEn = 1'b1; LoadAddr = 2'($urandom_range(0, 3)); LoadData = $urandom;
    end else begin
      LoadEn = 1'b0; LoadAddr = 2'($urandom_range(0, 3)); LoadData = $urandom;
    end
  endtask

  // Command fields wiggle while busy; the DUT must ignore them.
  task automatic cmd_noise();
    CmdValid    = 1'($urandom_range(0, 1));
    CmdFunSel   = 5'($urandom_range(0, 31));
    CmdSrcA     = 2'($urandom_range(0, 3));
    CmdSrcB     = 2'($urandom_range(0, 3));
    CmdDst      = 2'($urandom_range(0, 3));
    CmdWrite    = 1'($urandom_range(0, 1));
    CmdSetFlags = 1'($urandom_range(0, 1));
    CmdRep      = REP_W'($urandom_range(0, 15));
  endtask

  task automatic load_reg(input logic [1:0] addr, input logic [31:0] data);
    next_cycle();
    CmdValid = 1'b0; ResultReady = 1'b0;
    LoadEn = 1'b1; LoadAddr = addr; LoadData = data;
    push_idle();
    apply_load();
  endtask

  // Issue one command; cycle 0 is the acceptance cycle, ld_cycle selects the
  // cycle (relative to acceptance) that carries the explicit load.
  task automatic run_cmd(input logic [4:0] f, input logic [1:0] sa, input logic [1:0] sb,
                         input logic [1:0] d, input logic wr, input logic sf,
                         input logic [REP_W-1:0] rep, input int stall, input int ld_cycle,
                         input logic [1:0] la, input logic [31:0] ld, input logic rnd,
                         output logic [31:0] got);
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] acc;
    exp_t        e;
    int          cyc;
    cyc = 0;
    next_cycle();
    drive_load(cyc, ld_cycle, rnd, la, ld);
    CmdValid = 1'b1; CmdFunSel = f; CmdSrcA = sa; CmdSrcB = sb; CmdDst = d;
    CmdWrite = wr; CmdSetFlags = sf; CmdRep = rep;
    ResultReady = 1'($urandom_range(0, 1));
    push_idle();
    apply_load();
    op_a = m_bank[sa];
    op_b = m_bank[sb];
    acc  = op_a;
    for (int i = 0; i <= int'(rep); i++) begin
      cyc++;
      next_cycle();
      drive_load(cyc, ld_cycle, rnd, la, ld);
      cmd_noise();
      ResultReady = 1'($urandom_range(0, 1));
      e = '{a: acc, b: op_b, result: last_result, f: f, wf: sf, rv: 1'b0, ready: 1'b0};
      exp_q.push_back(e);
      apply_load();
      acc = alu_f(acc, op_b, f);
    end
    last_result = acc;
    if (wr) m_bank[d] = acc;
    for (int i = 0; i <= stall; i++) begin
      cyc++;
      next_cycle();
      drive_load(cyc, ld_cycle, rnd, la, ld);
      cmd_noise();
      CmdValid = 1'b1;
      ResultReady = (i == stall);
      e = '{a: 32'd0, b: 32'd0, result: last_result, f: 5'd0, wf: 1'b0, rv: 1'b1, ready: 1'b0};
      exp_q.push_back(e);
      apply_load();
    end
    next_cycle();
    LoadEn = 1'b0; CmdValid = 1'b0; ResultReady = 1'b0;
    push_idle();
    @(negedge Clock);
    got = Result;
  endtask

  task automatic read_reg(input logic [1:0] idx, output logic [31:0] got);
    run_cmd(OP_PASS, idx, 2'd0, 2'd0, 1'b0, 1'b0, '0, 0, -1, 2'd0, 32'd0, 1'b0, got);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_A"},           A,                32'd0);
    check({tag, "_B"},           B,                32'd0);
    check({tag, "_FunSel"},      32'(FunSel),      32'd0);
    check({tag, "_WF"},          32'(WF),          32'd0);
    check({tag, "_ResultValid"}, 32'(ResultValid), 32'd0);
    check({tag, "_Result"},      Result,           32'd0);
    check({tag, "_CmdReady"},    32'(CmdReady),    32'd1);
    check({tag, "_Busy"},        32'(Busy),        32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  logic [4:0]  ops [7];
  logic [31:0] got;

  initial begin
    ops = '{OP_PASS, OP_ADD, OP_SUB, OP_XOR, OP_LSL, OP_LSR, OP_ROL};
    n_checks = 0; n_pass = 0;
    last_result = '0;
    for (int i = 0; i < 4; i++) m_bank[i] = '0;
    Reset = 1'b0; CmdValid = 1'b0; CmdFunSel = '0; CmdSrcA = '0; CmdSrcB = '0;
    CmdDst = '0; CmdWrite = 1'b0; CmdSetFlags = 1'b0; CmdRep = '0;
    LoadEn = 1'b0; LoadAddr = '0; LoadData = '0; ResultReady = 1'b0;

    #3;
    check_reset_outputs("reset");
    check("reset_DebugState", 32'(DebugState), 32'd0);
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b1;

    // Single add: R0=5, R1=7, R2 <- R0+R1 with flags.
    load_reg(2'd0, 32'd5);
    load_reg(2'd1, 32'd7);
    run_cmd(OP_ADD, 2'd0, 2'd1, 2'd2, 1'b1, 1'b1, 4'd0, 0, -1, 2'd0, 32'd0, 1'b0, got);
    check("add_result", got, 32'd12);
    read_reg(2'd2, got);
    check("add_r2", got, 32'd12);

    // Repeat shift: R0=1, LSL x4 back into R0.
    load_reg(2'd0, 32'h0000_0001);
    run_cmd(OP_LSL, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 4'd3, 0, -1, 2'd0, 32'd0, 1'b0, got);
    check("shift_result", got, 32'd16);
    read_reg(2'd0, got);
    check("shift_r0", got, 32'd16);

    // Backpressure: ten stalled DONE cycles with CmdValid held high.
    run_cmd(OP_ROL, 2'd2, 2'd0, 2'd1, 1'b1, 1'b1, 4'd2, 10, -1, 2'd0, 32'd0, 1'b0, got);
    check("stall_result", got, 32'd96);

    // Load collision: final writeback of 0xAA to R3 beats a same-edge load of 0x55.
    load_reg(2'd0, 32'h0000_00AA);
    run_cmd(OP_PASS, 2'd0, 2'd0, 2'd3, 1'b1, 1'b0, 4'd0, 0, 1, 2'd3, 32'h55, 1'b0, got);
    read_reg(2'd3, got);
    check("collision_r3", got, 32'h0000_00AA);

    // Bypass: R1=9 loaded in the acceptance cycle is seen as B.
    load_reg(2'd0, 32'd3);
    run_cmd(OP_ADD, 2'd0, 2'd1, 2'd2, 1'b0, 1'b0, 4'd0, 0, 0, 2'd1, 32'd9, 1'b0, got);
    check("bypass_result", got, 32'd12);

    // Boundary: maximum repeat count (16 iterations).
    load_reg(2'd1, 32'h8000_0001);
    run_cmd(OP_ROL, 2'd1, 2'd0, 2'd1, 1'b1, 1'b1, 4'd15, 1, -1, 2'd0, 32'd0, 1'b0, got);
    check("maxrep_result", got, 32'h0001_8000);

    // Randomised commands with background loads.
    for (int n = 0; n < 60; n++) begin
      run_cmd(ops[$urandom_range(0, 6)], 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              REP_W'($urandom_range(0, 15)), $urandom_range(0, 3), -1, 2'd0, 32'd0, 1'b1, got);
    end

    // Reset in the middle of ISSUE: outputs clear at once, nothing is written.
    load_reg(2'd0, 32'hDEAD_BEEF);
    next_cycle();
    LoadEn = 1'b0; CmdValid = 1'b1; CmdFunSel = OP_LSL; CmdSrcA = 2'd0; CmdSrcB = 2'd0;
    CmdDst = 2'd1; CmdWrite = 1'b1; CmdSetFlags = 1'b1; CmdRep = 4'd5;
    push_idle();
    next_cycle();
    CmdValid = 1'b0;
    #1;
    check("preReset_A", A, 32'hDEAD_BEEF);
    check("preReset_WF", 32'(WF), 32'd1);
    #1 Reset = 1'b0;
    #1;
    check_reset_outputs("midReset");
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b1;
    for (int i = 0; i < 4; i++) m_bank[i] = '0;
    last_result = '0;
    for (int i = 0; i < 4; i++) begin
      read_reg(2'(i), got);
      check("postReset_bank", got, 32'd0);
    end

    repeat (2) @(posedge Clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
